cpu_run_monitor: RTL and testbench

- Synthesizable run controller that sits between the board/bench clock-reset source and the 65Org16-class CPU core inside the top-level design.
- Sequences CPU reset for a set number of cycles, counts run cycles, and decodes PASS/FAIL result writes to a fixed address.
- Enforces a cycle-count timeout and reports the outcome on sticky status flags and userled.
- Generalises the fixed-delay reset and fixed timeout of the existing bench flow to parametrised widths, hold length, result address and codes, so hardware and simulation share one mechanism.

---
 rtl/cpu_run_monitor_pkg.sv | 17 +
 rtl/cpu_run_monitor_trap_detector.sv | 70 +++++++
 rtl/cpu_run_monitor.sv | 189 ++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor_pkg
// Shared definitions for the CPU run monitor: controller state encoding and
// the default result-mailbox address / pass code used as parameter defaults.
// -----------------------------------------------------------------------------
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,   // CPU held in reset
        ST_RUN  = 2'd1,   // CPU running, cycles counted
        ST_DONE = 2'd2    // outcome latched, everything frozen
    } state_t;

    localparam logic [31:0] DEFAULT_RESULT_ADDR = 32'hFFFF_FFF0;
    localparam logic [15:0] DEFAULT_PASS_CODE   = 16'h600D;

endpackage

// File: rtl/cpu_run_monitor_trap_detector.sv
// -----------------------------------------------------------------------------
// trap_detector
// Watches opcode fetches while the CPU runs and flags a CPU stuck fetching the
// same address (a 6502 "JMP *" failure trap).
//
// Ports:
//   clk_i       clock, posedge
//   rst_ni      synchronous active-low reset
//   en_i        count fetches only while high (CPU in RUN)
//   sync_i      opcode-fetch strobe
//   addr_i      CPU address bus
//   trap_hit_o  one-cycle pulse: this fetch completes TRAP_REPEATS identical
//               consecutive fetches
// -----------------------------------------------------------------------------
module trap_detector #(
    parameter int ADDR_WIDTH   = 32,
    parameter int TRAP_REPEATS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  sync_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  trap_hit_o
);

    localparam int RPT_W = $clog2(TRAP_REPEATS + 1);

    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_vld_q, last_vld_d;
    logic [RPT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
    logic                  same_addr;

    // The valid bit keeps the first fetch after reset from matching the
    // cleared address register.
    assign same_addr = last_vld_q && (addr_i == last_addr_q);

    // rpt_cnt counts repeats beyond the first fetch; the hit fires on the
    // equal fetch that takes it to TRAP_REPEATS-1.
    assign trap_hit_o = en_i && sync_i && same_addr &&
                        (rpt_cnt_q == RPT_W'(TRAP_REPEATS - 2));

    always_comb begin
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        rpt_cnt_d   = rpt_cnt_q;
        if (en_i && sync_i) begin
            if (same_addr) begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end else begin
                last_addr_d = addr_i;
                last_vld_d  = 1'b1;
                rpt_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
// Run controller between the clock/reset source and the CPU core: holds the
// CPU in reset for RESET_CYCLES, counts run cycles, decodes PASS/FAIL writes
// to RESULT_ADDR, enforces a TIMEOUT_CYCLES limit and reports the outcome on
// sticky flags and userled.
//
// Optional build macro: CPU_RUN_MONITOR_TRAP_DETECT_EN enables detection of a
// CPU looping on one opcode address (trap flag). Without it trap is always 0.
//
// Ports:
//   phi0         clock, all logic on posedge
//   res          synchronous active-low reset
//   addr/dout/we CPU address, write data, write enable
//   sync         CPU opcode-fetch strobe
//   cpu_res      active-low reset to the CPU
//   done/pass/fail/timeout/trap  sticky status flags
//   result_code  last value written to RESULT_ADDR
//   cycle_count  run cycles elapsed
//   userled      {cpu_res, done, pass, fail, timeout, trap, result_code[1:0]},
//                registered (one cycle behind its sources)
// -----------------------------------------------------------------------------
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    RESET_CYCLES   = 2,
    parameter int                    TIMEOUT_CYCLES = 600,
    parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR    = ADDR_WIDTH'(DEFAULT_RESULT_ADDR),
    parameter logic [DATA_WIDTH-1:0] PASS_CODE      = DATA_WIDTH'(DEFAULT_PASS_CODE),
    parameter int                    HALT_ON_DONE   = 1,
    parameter int                    TRAP_REPEATS   = 4
) (
    input  logic                  phi0,
    input  logic                  res,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  we,
    input  logic                  sync,
    output logic                  cpu_res,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  trap,
    output logic [DATA_WIDTH-1:0] result_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [7:0]            userled
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  cpu_res_q, cpu_res_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic                  trap_q, trap_d;
    logic [DATA_WIDTH-1:0] result_code_q, result_code_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [7:0]            userled_q, userled_d;

    logic result_wr;
    logic timeout_hit;
    logic trap_hit;
    logic finish;

    assign result_wr   = we && (addr == RESULT_ADDR);
    assign timeout_hit = (cycle_count_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

`ifdef CPU_RUN_MONITOR_TRAP_DETECT_EN
    trap_detector #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .TRAP_REPEATS (TRAP_REPEATS)
    ) u_trap_detector (
        .clk_i      (phi0),
        .rst_ni     (res),
        .en_i       (state_q == ST_RUN),
        .sync_i     (sync),
        .addr_i     (addr),
        .trap_hit_o (trap_hit)
    );
`else
    localparam int UNUSED_TRAP_REPEATS = TRAP_REPEATS;
    logic unused_sync;
    assign unused_sync = sync;
    assign trap_hit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cpu_res_d     = cpu_res_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        trap_d        = trap_q;
        result_code_d = result_code_q;
        cycle_count_d = cycle_count_q;
        finish        = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    cpu_res_d = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Priority: result write, then trap, then timeout. The count
                // does not advance on the finishing cycle, so it freezes at the
                // value seen when the outcome was decided.
                if (result_wr) begin
                    result_code_d = dout;
                    if (dout == PASS_CODE) pass_d = 1'b1;
                    else                   fail_d = 1'b1;
                    finish = 1'b1;
                end else if (trap_hit) begin
                    trap_d = 1'b1;
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    finish    = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
                end
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (HALT_ON_DONE != 0) cpu_res_d = 1'b0;
                end
            end
            ST_DONE: begin
                // Frozen until res goes low.
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign userled_d = {cpu_res_q, done_q, pass_q, fail_q, timeout_q, trap_q,
                        result_code_q[1:0]};

    always_ff @(posedge phi0) begin
        if (!res) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            cpu_res_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            trap_q        <= 1'b0;
            result_code_q <= '0;
            cycle_count_q <= '0;
            userled_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cpu_res_q     <= cpu_res_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            trap_q        <= trap_d;
            result_code_q <= result_code_d;
            cycle_count_q <= cycle_count_d;
            userled_q     <= userled_d;
        end
    end

    assign cpu_res     = cpu_res_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign trap        = trap_q;
    assign result_code = result_code_q;
    assign cycle_count = cycle_count_q;
    assign userled     = userled_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
// Self-checking bench for cpu_run_monitor (default parameters). Each run
// scenario is a per-cycle bus plan; a reference model scans the plan with the
// outcome rules (first result write wins, otherwise a run of identical
// consecutive fetches if trap detection is built in, otherwise the timeout at
// the last allowed cycle) to predict the outcome and the frozen cycle count.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;

    localparam int          RESET_CYCLES = 2;
    localparam int          TIMEOUT      = 600;
    localparam int          TRAP_REPEATS = 4;
    localparam logic [31:0] RES_ADDR     = 32'hFFFF_FFF0;
    localparam logic [15:0] PASS_CODE    = 16'h600D;
`ifdef CPU_RUN_MONITOR_TRAP_DETECT_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        phi0 = 1'b0;
    logic        res  = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] dout = '0;
    logic        we   = 1'b0;
    logic        sync = 1'b0;
    logic        cpu_res, done, pass, fail, timeout, trap;
    logic [15:0] result_code;
    logic [31:0] cycle_count;
    logic [7:0]  userled;

    cpu_run_monitor dut (
        .phi0        (phi0),
        .res         (res),
        .addr        (addr),
        .dout        (dout),
        .we          (we),
        .sync        (sync),
        .cpu_res     (cpu_res),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .trap        (trap),
        .result_code (result_code),
        .cycle_count (cycle_count),
        .userled     (userled)
    );

    always #5 phi0 = ~phi0;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-run-cycle bus plan, index = value of cycle_count during that cycle.
    logic        p_we   [TIMEOUT];
    logic        p_sync [TIMEOUT];
    logic [31:0] p_addr [TIMEOUT];
    logic [15:0] p_dout [TIMEOUT];

    task automatic tick();
        @(posedge phi0);
        #1;
    endtask

    task automatic idle_bus();
        we = 1'b0; sync = 1'b0; addr = '0; dout = '0;
    endtask

    task automatic plan_idle();
        for (int k = 0; k < TIMEOUT; k++) begin
            p_we[k] = 1'b0; p_sync[k] = 1'b0; p_addr[k] = '0; p_dout[k] = '0;
        end
    endtask

    // Random bus traffic with no write to RES_ADDR itself (near misses only).
    task automatic plan_background(input bit with_sync);
        for (int k = 0; k < TIMEOUT; k++) begin
            p_we[k]   = ($urandom_range(0, 3) == 0);
            p_sync[k] = with_sync && ($urandom_range(0, 3) == 0);
            p_dout[k] = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                p_addr[k] = RES_ADDR ^ (32'h1 << $urandom_range(0, 31));
            else
                p_addr[k] = 32'h400 + 32'($urandom_range(0, 7)) * 4;
        end
    endtask

    // Reference model: kind = {pass, fail, timeout, trap}.
    task automatic model_outcome(output int term_k, output logic [3:0] kind,
                                 output logic [15:0] rc);
        logic [31:0] last_a;
        int          run_len;
        bit          have;
        have = 0; run_len = 0; last_a = '0;
        term_k = TIMEOUT - 1; kind = 4'b0010; rc = '0;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (p_we[k] && p_addr[k] == RES_ADDR) begin
                term_k = k; rc = p_dout[k];
                kind = (p_dout[k] == PASS_CODE) ? 4'b1000 : 4'b0100;
                return;
            end
            if (TRAP_EN && p_sync[k]) begin
                if (have && p_addr[k] == last_a) run_len++;
                else begin run_len = 1; last_a = p_addr[k]; have = 1; end
                if (run_len == TRAP_REPEATS) begin
                    term_k = k; kind = 4'b0001;
                    return;
                end
            end
        end
    endtask

    task automatic hold_reset(input int n);
        res = 1'b0;
        repeat (n) tick();
    endtask

    // Releases res and checks cpu_res rises on exactly the RESET_CYCLES-th edge.
    task automatic release_and_check(input string tag);
        res = 1'b1;
        idle_bus();
        for (int e = 1; e <= RESET_CYCLES; e++) begin
            tick();
            n_checks++;
            if (cpu_res !== (e == RESET_CYCLES))
                $display("FAIL %s cpu_res@edge%0d: got %b expected %b", tag, e,
                         cpu_res, (e == RESET_CYCLES));
            else n_pass++;
        end
        n_checks++;
        if (cycle_count !== 32'd0 || done !== 1'b0)
            $display("FAIL %s run_start: got cc=%0d done=%b expected cc=0 done=0",
                     tag, cycle_count, done);
        else n_pass++;
    endtask

    task automatic run_plan(input string tag);
        int          term_k, k;
        logic [3:0]  kind;
        logic [15:0] rc;
        bit          seen;
        logic [5:0]  exp_flags;
        model_outcome(term_k, kind, rc);
        exp_flags = {1'b0, 1'b1, kind};
        hold_reset(3);
        release_and_check(tag);
        k = 0; seen = 0;
        while (!seen && k < TIMEOUT + 4) begin
            if (k < TIMEOUT) begin
                we = p_we[k]; sync = p_sync[k]; addr = p_addr[k]; dout = p_dout[k];
            end else idle_bus();
            tick();
            if (done) seen = 1;
            else k++;
        end
        idle_bus();
        $display("%s: done=%b at run cycle %0d, expected %0d kind=%b rc=%h",
                 tag, seen, k, term_k, kind, rc);
        n_checks++;
        if (!seen || k != term_k)
            $display("FAIL %s done_cycle: got seen=%b k=%0d expected k=%0d", tag, seen, k, term_k);
        else n_pass++;
        n_checks++;
        if ({cpu_res, done, pass, fail, timeout, trap} !== exp_flags)
            $display("FAIL %s flags: got %b expected %b", tag,
                     {cpu_res, done, pass, fail, timeout, trap}, exp_flags);
        else n_pass++;
        n_checks++;
        if (result_code !== rc || cycle_count !== 32'(term_k))
            $display("FAIL %s result: got rc=%h cc=%0d expected rc=%h cc=%0d", tag,
                     result_code, cycle_count, rc, term_k);
        else n_pass++;
        // Late pass writes and fetches must not disturb a finished run.
        we = 1'b1; addr = RES_ADDR; dout = PASS_CODE; sync = 1'b1;
        repeat (3) tick();
        idle_bus();
        n_checks++;
        if ({cpu_res, done, pass, fail, timeout, trap} !== exp_flags ||
            result_code !== rc || cycle_count !== 32'(term_k))
            $display("FAIL %s frozen: got flags=%b rc=%h cc=%0d expected flags=%b rc=%h cc=%0d",
                     tag, {cpu_res, done, pass, fail, timeout, trap}, result_code,
                     cycle_count, exp_flags, rc, term_k);
        else n_pass++;
        n_checks++;
        if (userled !== {exp_flags, rc[1:0]})
            $display("FAIL %s userled: got %h expected %h", tag, userled, {exp_flags, rc[1:0]});
        else n_pass++;
    endtask

    task automatic test_reset();
        // A result write while res is low must be ignored.
        we = 1'b1; addr = RES_ADDR; dout = PASS_CODE; sync = 1'b1;
        hold_reset(3);
        n_checks++;
        if ({cpu_res, done, pass, fail, timeout, trap} !== 6'b0 || result_code !== 16'h0 ||
            cycle_count !== 32'h0 || userled !== 8'h00)
            $display("FAIL reset_values: got flags=%b rc=%h cc=%0d led=%h expected all 0",
                     {cpu_res, done, pass, fail, timeout, trap}, result_code, cycle_count, userled);
        else n_pass++;
        $display("test_reset: reset values sampled");
        release_and_check("test_reset");
        tick();
        n_checks++;
        if (userled !== 8'h80 || cycle_count !== 32'd1)
            $display("FAIL reset_led: got led=%h cc=%0d expected led=80 cc=1", userled, cycle_count);
        else n_pass++;
    endtask

    task automatic test_pass();
        plan_idle();
        p_we[50] = 1'b1; p_addr[50] = RES_ADDR; p_dout[50] = PASS_CODE;
        run_plan("test_pass");
    endtask

    task automatic test_fail();
        int k;
        plan_background(1'b0);
        k = $urandom_range(10, 500);
        p_we[k] = 1'b1; p_addr[k] = RES_ADDR; p_dout[k] = 16'h0BAD;
        run_plan("test_fail");
    endtask

    task automatic test_timeout();
        plan_background(1'b0);
        run_plan("test_timeout");
    endtask

    task automatic test_write_at_timeout();
        plan_background(1'b0);
        p_we[TIMEOUT-1] = 1'b1; p_addr[TIMEOUT-1] = RES_ADDR; p_dout[TIMEOUT-1] = PASS_CODE;
        run_plan("test_write_at_timeout");
    endtask

    task automatic test_mid_reset();
        plan_background(1'b0);
        hold_reset(2);
        release_and_check("test_mid_reset_a");
        for (int k = 0; k < 100; k++) begin
            we = p_we[k]; sync = 1'b0; addr = p_addr[k]; dout = p_dout[k];
            tick();
        end
        n_checks++;
        if (cycle_count !== 32'd100 || done !== 1'b0)
            $display("FAIL mid_reset_run: got cc=%0d done=%b expected cc=100 done=0", cycle_count, done);
        else n_pass++;
        hold_reset(1);
        n_checks++;
        if ({cpu_res, done, pass, fail, timeout, trap} !== 6'b0 || result_code !== 16'h0 ||
            cycle_count !== 32'h0 || userled !== 8'h00)
            $display("FAIL mid_reset_values: got flags=%b rc=%h cc=%0d led=%h expected all 0",
                     {cpu_res, done, pass, fail, timeout, trap}, result_code, cycle_count, userled);
        else n_pass++;
        $display("test_mid_reset: res pulsed at run cycle 100");
        release_and_check("test_mid_reset_b");
    endtask

    task automatic test_trap();
        plan_background(1'b0);
        for (int k = 30; k < 34; k++) begin
            p_sync[k] = 1'b1; p_we[k] = 1'b0; p_addr[k] = 32'h0000_0400;
        end
        run_plan("test_trap");
    endtask

    // Four fetches at the result address; the fourth also writes a fail code,
    // so the write must beat the trap.
    task automatic test_trap_vs_write();
        plan_background(1'b0);
        for (int k = 40; k < 44; k++) begin
            p_sync[k] = 1'b1; p_we[k] = 1'b0; p_addr[k] = RES_ADDR;
        end
        p_we[43] = 1'b1; p_dout[43] = 16'h1234;
        run_plan("test_trap_vs_write");
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 8; i++) begin
            plan_background(1'b1);
            if ($urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, TIMEOUT - 1);
                p_we[k] = 1'b1; p_addr[k] = RES_ADDR;
                p_dout[k] = ($urandom_range(0, 1) == 0) ? PASS_CODE : 16'($urandom);
            end
            run_plan($sformatf("test_random_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_write_at_timeout();
        test_mid_reset();
        test_trap();
        test_trap_vs_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
